// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs PACK consecutive FIFO words into one valid/ready beat, with flush of partial beats.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK = 4
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic                       empty,
    output logic                       r_en,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [PACK*DATA_WIDTH-1:0] m_data,
    output logic [PACK-1:0]            m_keep
);
    localparam int CW = $clog2(PACK + 1);
    localparam int IW = $clog2(PACK);
    localparam logic [CW-1:0] FULL = CW'(PACK);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [PACK-1:0][DATA_WIDTH-1:0] acc, acc_nx, beat;
    logic [CW-1:0] cnt, cnt_nx;
    logic [PACK-1:0] keep_nx;
    logic inflight, flush_pend, flush_pend_nx, out_free, fl, last, load;

    always_comb begin
        out_free = !m_valid || m_ready;
        fl = flush_pend || flush;
        last = inflight && cnt == LAST;
        // A pop may overlap the final-lane capture only when that beat is sure to go straight out.
        r_en = !rrst && !empty && !fl &&
               (({1'b0, cnt} + {{CW{1'b0}}, inflight} < {1'b0, FULL}) || (last && !m_valid));
        acc_nx = acc;
        cnt_nx = cnt;
        flush_pend_nx = fl;
        load = 1'b0;
        beat = acc;
        keep_nx = '1;
        if (inflight) begin
            acc_nx[cnt[IW-1:0]] = data_out;
            if (last) begin
                load = out_free;
                beat = acc_nx;
                cnt_nx = out_free ? '0 : FULL;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end else if (cnt == FULL) begin
            load = out_free;
            cnt_nx = out_free ? '0 : FULL;
        end else if (fl) begin
            load = cnt != '0 && out_free;
            flush_pend_nx = cnt != '0 && !out_free;
            cnt_nx = load ? '0 : cnt;
            for (int i = 0; i < PACK; i++) begin
                keep_nx[i] = i < int'(cnt);
                beat[i] = keep_nx[i] ? acc[i] : '0;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            acc <= '0;
            cnt <= '0;
            inflight <= 1'b0;
            flush_pend <= 1'b0;
            m_valid <= 1'b0;
            m_data <= '0;
            m_keep <= '0;
        end else begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            inflight <= r_en;
            flush_pend <= flush_pend_nx;
            if (load) begin
                m_valid <= 1'b1;
                m_data <= beat;
                m_keep <= keep_nx;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule
